// File: rtl/csr_file_m_if.sv
// Pipeline <-> machine-mode CSR file bus: CSR access, trap/return events and redirect targets.
interface csr_if #(
  parameter int XLEN = 64
);
  logic [11:0]     csr_idx;
  logic            csr_wr_en;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wr_data;
  logic [XLEN-1:0] csr_rd_data;
  logic            csr_illegal;
  logic            ecall;
  logic            mret;
  logic            intr_take;
  logic [XLEN-1:0] exc_pc;
  logic            irq_timer;
  logic            irq_req;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mret_target;

  modport master (
    output csr_idx, csr_wr_en, csr_op, csr_wr_data, ecall, mret, intr_take, exc_pc, irq_timer,
    input  csr_rd_data, csr_illegal, irq_req, trap_target, mret_target
  );

  modport slave (
    input  csr_idx, csr_wr_en, csr_op, csr_wr_data, ecall, mret, intr_take, exc_pc, irq_timer,
    output csr_rd_data, csr_illegal, irq_req, trap_target, mret_target
  );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSR rd/wr/set/clear, ecall/mret/timer-interrupt trap state, redirect targets.
// Reads and targets are combinational; all state updates land on the next clk edge.
module csr_file_m #(
  parameter int          XLEN        = 64,
  parameter logic [63:0] MSTATUS_RST = 64'h0000000a00001800,
  parameter logic [63:0] MTVEC_RST   = 64'h0
) (
  input logic   clk,
  input logic   rst_n,
  csr_if.slave  bus
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;

  localparam logic [XLEN-1:0] MSTATUS_INIT = MSTATUS_RST[XLEN-1:0];
  localparam logic [XLEN-1:0] MTVEC_INIT   = MTVEC_RST[XLEN-1:0];
  localparam logic [XLEN-1:0] CAUSE_MTI    = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);

  logic [XLEN-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mcycle_q;
  logic            mtie_q;

  logic [XLEN-1:0] rd_val, wr_val, tvec_base;
  logic            illegal;
  logic            intr_fire, ecall_fire, mret_fire, csr_fire;

  always_comb begin
    rd_val  = '0;
    illegal = 1'b0;
    case (bus.csr_idx)
      A_MSTATUS:  rd_val = mstatus_q;
      A_MIE:      rd_val = XLEN'(mtie_q) << 7;
      A_MTVEC:    rd_val = mtvec_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = mepc_q;
      A_MCAUSE:   rd_val = mcause_q;
      A_MIP:      rd_val = XLEN'(bus.irq_timer) << 7;
      A_MCYCLE:   rd_val = mcycle_q;
      default:    illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (bus.csr_op)
      2'b01:   wr_val = bus.csr_wr_data;
      2'b10:   wr_val = rd_val | bus.csr_wr_data;
      2'b11:   wr_val = rd_val & ~bus.csr_wr_data;
      default: wr_val = rd_val;
    endcase
  end

  assign bus.csr_rd_data = rd_val;
  assign bus.csr_illegal = illegal;
  assign bus.irq_req     = mstatus_q[3] & mtie_q & bus.irq_timer;
  assign bus.mret_target = mepc_q;

  // An intr_take without a live request is treated as absent, so lower-priority events still fire.
  assign intr_fire  = bus.intr_take & bus.irq_req;
  assign ecall_fire = bus.ecall & ~intr_fire;
  assign mret_fire  = bus.mret & ~intr_fire & ~bus.ecall;
  assign csr_fire   = bus.csr_wr_en & (bus.csr_op != 2'b00) & ~illegal
                    & ~intr_fire & ~bus.ecall & ~bus.mret;

  assign tvec_base       = {mtvec_q[XLEN-1:2], 2'b00};
  assign bus.trap_target = (mtvec_q[1:0] == 2'b01 && intr_fire) ? tvec_base + XLEN'(28) : tvec_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_INIT;
      mtvec_q    <= MTVEC_INIT;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      mtie_q     <= 1'b0;
    end else begin
      mcycle_q <= mcycle_q + 1'b1;
      if (intr_fire || ecall_fire) begin
        mepc_q            <= {bus.exc_pc[XLEN-1:2], 2'b00};
        mcause_q          <= intr_fire ? CAUSE_MTI : CAUSE_ECALL;
        mstatus_q[7]      <= mstatus_q[3];
        mstatus_q[3]      <= 1'b0;
        mstatus_q[12:11]  <= 2'b11;
      end else if (mret_fire) begin
        mstatus_q[3]      <= mstatus_q[7];
        mstatus_q[7]      <= 1'b1;
        mstatus_q[12:11]  <= 2'b11;
      end else if (csr_fire) begin
        case (bus.csr_idx)
          A_MSTATUS:  mstatus_q  <= wr_val;
          A_MIE:      mtie_q     <= wr_val[7];
          // Reserved vector modes 1x keep the current mode; the base still updates.
          A_MTVEC:    mtvec_q    <= wr_val[1] ? {wr_val[XLEN-1:2], mtvec_q[1:0]} : wr_val;
          A_MSCRATCH: mscratch_q <= wr_val;
          A_MEPC:     mepc_q     <= {wr_val[XLEN-1:2], 2'b00};
          A_MCAUSE:   mcause_q   <= wr_val;
          A_MCYCLE:   mcycle_q   <= wr_val;
          default:    ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m: expected values queued at drive time, popped when the DUT is sampled.
module tb_csr_file_m;
  localparam logic [63:0] RST = 64'h0000000a00001800;
  localparam logic [63:0] ONES = {64{1'b1}};
  localparam logic [63:0] CMTI = 64'h8000000000000007;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] exp_q[$];

  csr_if #(.XLEN(64)) bus();

  csr_file_m #(.XLEN(64), .MSTATUS_RST(RST), .MTVEC_RST(64'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] idx, input logic [63:0] v);
    expect_val(v);
    bus.csr_idx = idx;
    #1;
    chk(tag, bus.csr_rd_data);
  endtask

  task automatic wr(input logic [11:0] idx, input logic [1:0] op, input logic [63:0] d);
    bus.csr_idx     = idx;
    bus.csr_op      = op;
    bus.csr_wr_data = d;
    bus.csr_wr_en   = 1'b1;
    tick();
    bus.csr_wr_en   = 1'b0;
    bus.csr_op      = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.csr_idx = 12'h0; bus.csr_wr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_wr_data = '0;
    bus.ecall = 1'b0; bus.mret = 1'b0; bus.intr_take = 1'b0; bus.exc_pc = '0; bus.irq_timer = 1'b0;
    tick(); tick();

    // reset state and mcycle start
    rd_chk("rst_mstatus", 12'h300, RST);
    rd_chk("rst_mtvec",   12'h305, 64'h0);
    rd_chk("rst_mepc",    12'h341, 64'h0);
    rd_chk("rst_mcause",  12'h342, 64'h0);
    rd_chk("rst_mie",     12'h304, 64'h0);
    expect_val(64'h0); chk("rst_irq_req", 64'(bus.irq_req));
    tick();
    rst_n = 1'b1;
    rd_chk("mcycle_0", 12'hB00, 64'd0);
    tick(); rd_chk("mcycle_1", 12'hB00, 64'd1);
    tick(); rd_chk("mcycle_2", 12'hB00, 64'd2);

    // RW / RS / RC; read during the write cycle shows the old value
    bus.csr_idx = 12'h305; bus.csr_op = 2'b01; bus.csr_wr_data = 64'h8000_0100; bus.csr_wr_en = 1'b1;
    expect_val(64'h0);
    #1 chk("rw_old_val", bus.csr_rd_data);
    tick();
    bus.csr_wr_en = 1'b0; bus.csr_op = 2'b00;
    wr(12'h300, 2'b10, 64'h8);
    rd_chk("mtvec_rw", 12'h305, 64'h8000_0100);
    rd_chk("mstatus_rs", 12'h300, RST | 64'h8);
    wr(12'h300, 2'b11, 64'h8);
    rd_chk("mstatus_rc", 12'h300, RST);

    // ecall then mret
    wr(12'h300, 2'b10, 64'h8);
    bus.ecall = 1'b1; bus.exc_pc = 64'h8000_0010;
    expect_val(64'h8000_0100);
    #1 chk("ecall_target", bus.trap_target);
    tick();
    bus.ecall = 1'b0;
    rd_chk("ecall_mepc",    12'h341, 64'h8000_0010);
    rd_chk("ecall_mcause",  12'h342, 64'd11);
    rd_chk("ecall_mstatus", 12'h300, RST | 64'h80);
    bus.mret = 1'b1;
    expect_val(64'h8000_0010);
    #1 chk("mret_target", bus.mret_target);
    tick();
    bus.mret = 1'b0;
    rd_chk("mret_mstatus", 12'h300, RST | 64'h88);

    // timer interrupt, vectored mode
    wr(12'h304, 2'b01, ONES);
    rd_chk("mie_mask", 12'h304, 64'h80);
    bus.irq_timer = 1'b1;
    expect_val(64'h1);
    #1 chk("irq_req_hi", 64'(bus.irq_req));
    rd_chk("mip_timer", 12'h344, 64'h80);
    wr(12'h305, 2'b01, 64'h8000_0101);
    bus.intr_take = 1'b1; bus.exc_pc = 64'h8000_0040;
    expect_val(64'h8000_011C);
    #1 chk("intr_target", bus.trap_target);
    tick();
    bus.intr_take = 1'b0;
    rd_chk("intr_mcause",  12'h342, CMTI);
    rd_chk("intr_mepc",    12'h341, 64'h8000_0040);
    rd_chk("intr_mstatus", 12'h300, RST | 64'h80);
    expect_val(64'h0); chk("irq_req_masked", 64'(bus.irq_req));

    // intr_take without a request is ignored
    wr(12'h304, 2'b01, 64'h0);
    wr(12'h300, 2'b10, 64'h8);
    bus.intr_take = 1'b1; bus.exc_pc = 64'h1234;
    expect_val(64'h0);
    #1 chk("irq_req_mie0", 64'(bus.irq_req));
    expect_val(64'h8000_0100); chk("noirq_target", bus.trap_target);
    tick();
    bus.intr_take = 1'b0;
    rd_chk("noirq_mepc",    12'h341, 64'h8000_0040);
    rd_chk("noirq_mcause",  12'h342, CMTI);
    rd_chk("noirq_mstatus", 12'h300, RST | 64'h88);

    // intr_take + ecall + CSR write in one cycle: interrupt only
    wr(12'h304, 2'b01, 64'h80);
    bus.intr_take = 1'b1; bus.ecall = 1'b1; bus.exc_pc = 64'h8000_0200;
    bus.csr_idx = 12'h341; bus.csr_op = 2'b01; bus.csr_wr_data = 64'hDEAD_0000; bus.csr_wr_en = 1'b1;
    tick();
    bus.intr_take = 1'b0; bus.ecall = 1'b0; bus.csr_wr_en = 1'b0; bus.csr_op = 2'b00;
    rd_chk("prio_mepc",    12'h341, 64'h8000_0200);
    rd_chk("prio_mcause",  12'h342, CMTI);
    rd_chk("prio_mstatus", 12'h300, RST | 64'h80);

    // mcycle wrap, unimplemented address, write masks
    wr(12'hB00, 2'b01, ONES);
    rd_chk("mcycle_ones", 12'hB00, ONES);
    tick();
    rd_chk("mcycle_wrap", 12'hB00, 64'h0);
    rd_chk("illegal_rd", 12'h7C0, 64'h0);
    expect_val(64'h1); chk("illegal_flag", 64'(bus.csr_illegal));
    bus.csr_idx = 12'h300;
    expect_val(64'h0);
    #1 chk("legal_flag", 64'(bus.csr_illegal));
    wr(12'h341, 2'b01, 64'h8000_0013);
    rd_chk("mepc_align", 12'h341, 64'h8000_0010);
    wr(12'h305, 2'b01, 64'h8000_0302);
    rd_chk("mtvec_mode_keep", 12'h305, 64'h8000_0301);

    // reset while an ecall commits
    bus.ecall = 1'b1; bus.exc_pc = 64'h99;
    rst_n = 1'b0;
    tick();
    bus.ecall = 1'b0;
    rd_chk("rst_trap_mstatus", 12'h300, RST);
    rd_chk("rst_trap_mepc",    12'h341, 64'h0);
    rd_chk("rst_trap_mtvec",   12'h305, 64'h0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
